pipe_cla_addsub: RTL and testbench
==================================

Name: pipe_cla_addsub

Overview:
- Parametrised, 3-stage pipelined carry-lookahead adder/subtractor with valid/ready handshaking at both ends.
- Operands are signed two's complement, WIDTH bits. The per-transaction output format is either exact two's complement or sign-magnitude (with a saturation flag).
- Successor to the single-cycle combinational group-CLA adder. It sits between the operand-select stage and the writeback/display formatting path.

Parameters:
- WIDTH, 32, operand width in bits. Must equal GROUP * NGRP.
- GROUP, 4, bits per lookahead group. Must divide WIDTH.
- NGRP, WIDTH/GROUP, derived group count. Must be a power of two, at least 2.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- clr  in  1  synchronous flush of all in-flight transactions
- in_valid  in  1  input transaction present
- in_ready  out  1  block accepts the input this cycle
- a  in  WIDTH  operand A, signed
- b  in  WIDTH  operand B, signed
- sub  in  1  0: A+B; 1: A-B
- fmt  in  1  0: two's complement result; 1: sign-magnitude result
- out_valid  out  1  result present
- out_ready  in  1  downstream accepts the result
- result  out  WIDTH+1  formatted result
- cout  out  1  unsigned carry-out of the WIDTH-bit operation (for sub: 1 = no borrow)
- ovf  out  1  fmt=1 only: magnitude saturated

Behaviour:
- Reset: rst_n low asynchronously clears all stage valid bits and all data registers. Outputs: out_valid=0, result=0, cout=0, ovf=0, in_ready=0 while rst_n is low. A reset mid-operation discards all in-flight transactions; none is emitted afterwards.
- Operand conditioning: b_eff = sub ? ~b : b; carry-in c0 = sub.
- S1: per group, compute group generate/propagate and register them. Also register the per-bit p = a^b_eff, the sign bits a[W-1], b_eff[W-1], c0, and fmt.
- S2: Kogge-Stone prefix over NGRP group (g,p) pairs with c0 folded in at group 0. Registers the group carry-ins cin[0..NGRP]. cout = cin[NGRP].
- S3:
  - Sum: s = p ^ bit-carries, where bit carries are rippled within each group from cin[i].
  - Exact sum: e = {sign extension of S1 operands, s}, i.e. e[WIDTH] = a[W-1] ^ b_eff[W-1] ^ cout. e is the exact (WIDTH+1)-bit signed value.
  - fmt=0: result = e, ovf = 0.
  - fmt=1: result[WIDTH] = e[WIDTH]; result[WIDTH-1:0] = |e|.
  - |e| = 2^WIDTH only for e = -2^WIDTH. In that case the magnitude saturates to all ones and ovf=1.
- Latency: 3 cycles from acceptance to out_valid, with no stalls. Throughput is 1 transaction/cycle.
- Elastic pipeline:
  - Each stage k holds v_k and advances when !v_{k+1} or stage k+1 advances. S3 advances on out_ready.
  - in_ready = !clr && (!v1 || S1 advances).
  - Accept on in_valid && in_ready.
  - Order is strictly preserved; there is no loss and no duplication.
- Output stability: while out_valid && !out_ready, result, cout and ovf hold stable.
- clr: at the next edge, v1..v3 are cleared. An input presented in the same cycle is not accepted, and out_valid is 0 on the following cycle. Data registers need not be cleared.
- Simultaneous clr and out_ready: the clr flush takes priority; the transfer is dropped.

Decomposition:
- Package pipe_cla_pkg holds:
  - fmt constants FMT_TC=0 and FMT_SM=1;
  - stage count constant PIPE_STAGES=3;
  - a function that checks the parameter legality (divisibility and power of two).
- Sub-module cla_group_pg(GROUP) computes the group (g,p) and per-bit p. It is instantiated NGRP times in S1.
- The prefix tree and the S3 ripple stay inline.

Test Plan (WIDTH=8, GROUP=4):
- a=100, b=27, sub=0, fmt=0, out_ready=1 -> result=9'h07F, cout=0, ovf=0, out_valid exactly 3 cycles after acceptance.
- a=-128, b=-128, sub=0: fmt=0 -> 9'h100, cout=1, ovf=0; fmt=1 -> sign=1, mag=8'hFF, ovf=1.
- a=5, b=9, sub=1: fmt=0 -> 9'h1FC, cout=0; fmt=1 -> 9'h104, ovf=0.
- Back-to-back inputs 1+1, 2+2, 3+3, 4+4 with out_ready=0 for 6 cycles:
  - exactly 3 are accepted, then in_ready=0 and result holds 9'h002;
  - after out_ready=1, results 2, 4, 6, 8 appear in order, one per cycle.
- 2 transactions in flight, then rst_n pulsed low mid-cycle -> out_valid drops immediately, and nothing is emitted after release.
- clr asserted with in_valid=1 and 3 in flight -> in_ready=0 that cycle, out_valid=0 next cycle, and the next accepted transaction emerges with normal 3-cycle latency.

Source files
------------

// File: rtl/pipe_cla_pkg.sv
// Shared constants and elaboration helpers for the pipelined CLA adder/subtractor.
package pipe_cla_pkg;

    localparam logic FMT_TC = 1'b0;
    localparam logic FMT_SM = 1'b1;

    localparam int unsigned PIPE_STAGES = 32'd3;

    // WIDTH must split into NGRP equal groups, NGRP a power of two and at least 2.
    function automatic logic params_legal(input int width, input int group, input int ngrp);
        logic ok_s;
        if (group <= 32'sd0) begin
            ok_s = 1'b0;
        end else begin
            ok_s = (width == group * ngrp) && ((width % group) == 32'sd0) &&
                   (ngrp >= 32'sd2) && ((ngrp & (ngrp - 32'sd1)) == 32'sd0);
        end
        return ok_s;
    endfunction

endpackage

// File: rtl/pipe_cla_addsub_if.sv
// Operand/result handshake bundle between operand select and writeback formatting.
interface pipe_cla_addsub_if #(parameter int WIDTH = 32);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             fmt;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH:0]   result;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, sub, fmt, out_ready,
        input  in_ready, out_valid, result, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, sub, fmt, out_ready,
        output in_ready, out_valid, result, cout, ovf
    );

endinterface

// File: rtl/pipe_cla_addsub_pg.sv
// One lookahead group: per-bit generate/propagate and the group (g,p) pair.
module cla_group_pg #(
    parameter int GROUP = 4
) (
    input  logic [GROUP-1:0] a,
    input  logic [GROUP-1:0] b,
    output logic             g_grp,
    output logic             p_grp,
    output logic [GROUP-1:0] g_bit,
    output logic [GROUP-1:0] p_bit
);

    assign p_bit = a ^ b;
    assign g_bit = a & b;
    assign p_grp = &p_bit;

    // Group generate: carry out of the group assuming a zero carry-in.
    always_comb begin
        g_grp = 1'b0;
        for (int j = 0; j < GROUP; j++) begin
            g_grp = g_bit[j] | (p_bit[j] & g_grp);
        end
    end

endmodule

// File: rtl/pipe_cla_addsub.sv
// Three-stage elastic carry-lookahead adder/subtractor producing a (WIDTH+1)-bit
// exact two's complement or saturating sign-magnitude result.
module pipe_cla_addsub
    import pipe_cla_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int GROUP = 4,
    parameter int NGRP  = WIDTH / GROUP
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    pipe_cla_addsub_if.slave  bus
);

    localparam int LVLS = $clog2(NGRP);

    if (!params_legal(WIDTH, GROUP, NGRP)) begin : g_bad_params
        $error("pipe_cla_addsub: WIDTH must equal GROUP*NGRP with NGRP a power of two >= 2");
    end

    logic v1_r, v2_r, v3_r;
    logic adv1_s, adv2_s, adv3_s, acc_s;

    // A stage moves forward when the next one is empty or moving itself.
    assign adv3_s        = v3_r & bus.out_ready;
    assign adv2_s        = v2_r & (~v3_r | adv3_s);
    assign adv1_s        = v1_r & (~v2_r | adv2_s);
    assign bus.in_ready  = rst_n & ~clr & (~v1_r | adv1_s);
    assign acc_s         = bus.in_valid & bus.in_ready;
    assign bus.out_valid = v3_r;

    // Stage occupancy; clr flushes everything in flight, even a pending output transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_r <= 1'b0;
            v2_r <= 1'b0;
            v3_r <= 1'b0;
        end else if (clr) begin
            v1_r <= 1'b0;
            v2_r <= 1'b0;
            v3_r <= 1'b0;
        end else begin
            v1_r <= acc_s  | (v1_r & ~adv1_s);
            v2_r <= adv1_s | (v2_r & ~adv2_s);
            v3_r <= adv2_s | (v3_r & ~adv3_s);
        end
    end

    // ---------------- S1: operand conditioning and group (g,p) ----------------
    logic [WIDTH-1:0] b_eff_s;
    logic [NGRP-1:0]  g_grp_s, p_grp_s;
    logic [WIDTH-1:0] g_bit_s, p_bit_s;

    assign b_eff_s = bus.sub ? ~bus.b : bus.b;

    for (genvar i = 0; i < NGRP; i++) begin : g_pg
        cla_group_pg #(.GROUP(GROUP)) u_pg (
            .a     (bus.a[i*GROUP +: GROUP]),
            .b     (b_eff_s[i*GROUP +: GROUP]),
            .g_grp (g_grp_s[i]),
            .p_grp (p_grp_s[i]),
            .g_bit (g_bit_s[i*GROUP +: GROUP]),
            .p_bit (p_bit_s[i*GROUP +: GROUP])
        );
    end

    logic [NGRP-1:0]  g_grp1_r, p_grp1_r;
    logic [WIDTH-1:0] g_bit1_r, p_bit1_r;
    logic             a_msb1_r, b_msb1_r, c0_1_r, fmt1_r;

    // S1 data registers, loaded on input acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            g_grp1_r <= '0;
            p_grp1_r <= '0;
            g_bit1_r <= '0;
            p_bit1_r <= '0;
            a_msb1_r <= 1'b0;
            b_msb1_r <= 1'b0;
            c0_1_r   <= 1'b0;
            fmt1_r   <= 1'b0;
        end else if (acc_s) begin
            g_grp1_r <= g_grp_s;
            p_grp1_r <= p_grp_s;
            g_bit1_r <= g_bit_s;
            p_bit1_r <= p_bit_s;
            a_msb1_r <= bus.a[WIDTH-1];
            b_msb1_r <= b_eff_s[WIDTH-1];
            c0_1_r   <= bus.sub;
            fmt1_r   <= bus.fmt;
        end else begin
            g_grp1_r <= g_grp1_r;
            p_grp1_r <= p_grp1_r;
            g_bit1_r <= g_bit1_r;
            p_bit1_r <= p_bit1_r;
            a_msb1_r <= a_msb1_r;
            b_msb1_r <= b_msb1_r;
            c0_1_r   <= c0_1_r;
            fmt1_r   <= fmt1_r;
        end
    end

    // ---------------- S2: Kogge-Stone prefix over the groups ----------------
    logic [NGRP:0] cin_s;

    // Carry-in folded into group 0 so every prefix G[0..i] is directly cin[i+1].
    always_comb begin
        logic [NGRP-1:0] gk, pk, gn, pn;
        int              span, src;
        gk    = g_grp1_r;
        gk[0] = g_grp1_r[0] | (p_grp1_r[0] & c0_1_r);
        pk    = p_grp1_r;
        gn    = gk;
        pn    = pk;
        for (int l = 0; l < LVLS; l++) begin
            span = 32'sd1 << l;
            for (int i = 0; i < NGRP; i++) begin
                src = (i >= span) ? (i - span) : 32'sd0;
                if (i >= span) begin
                    gn[i] = gk[i] | (pk[i] & gk[src]);
                    pn[i] = pk[i] & pk[src];
                end else begin
                    gn[i] = gk[i];
                    pn[i] = pk[i];
                end
            end
            gk = gn;
            pk = pn;
        end
        cin_s = {gk, c0_1_r};
    end

    logic [NGRP:0]    cin2_r;
    logic [WIDTH-1:0] g_bit2_r, p_bit2_r;
    logic             a_msb2_r, b_msb2_r, fmt2_r;

    // S2 data registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cin2_r   <= '0;
            g_bit2_r <= '0;
            p_bit2_r <= '0;
            a_msb2_r <= 1'b0;
            b_msb2_r <= 1'b0;
            fmt2_r   <= 1'b0;
        end else if (adv1_s) begin
            cin2_r   <= cin_s;
            g_bit2_r <= g_bit1_r;
            p_bit2_r <= p_bit1_r;
            a_msb2_r <= a_msb1_r;
            b_msb2_r <= b_msb1_r;
            fmt2_r   <= fmt1_r;
        end else begin
            cin2_r   <= cin2_r;
            g_bit2_r <= g_bit2_r;
            p_bit2_r <= p_bit2_r;
            a_msb2_r <= a_msb2_r;
            b_msb2_r <= b_msb2_r;
            fmt2_r   <= fmt2_r;
        end
    end

    // ---------------- S3: in-group ripple and output formatting ----------------
    logic [WIDTH-1:0] sum_s;
    logic [WIDTH:0]   exact_s, neg_s, res_s;
    logic             sat_s, ovf_s;

    // Bit carries ripple inside each group starting from its lookahead carry-in.
    always_comb begin
        logic c;
        c     = 1'b0;
        sum_s = '0;
        for (int i = 0; i < NGRP; i++) begin
            c = cin2_r[i];
            for (int j = 0; j < GROUP; j++) begin
                sum_s[i*GROUP + j] = p_bit2_r[i*GROUP + j] ^ c;
                c = g_bit2_r[i*GROUP + j] | (p_bit2_r[i*GROUP + j] & c);
            end
        end
    end

    assign exact_s = {a_msb2_r ^ b_msb2_r ^ cin2_r[NGRP], sum_s};
    assign neg_s   = (~exact_s) + {{WIDTH{1'b0}}, 1'b1};
    // Only -2^WIDTH has a magnitude that does not fit in WIDTH bits.
    assign sat_s   = exact_s[WIDTH] & ~(|exact_s[WIDTH-1:0]);

    // Result formatting.
    always_comb begin
        res_s = exact_s;
        ovf_s = 1'b0;
        if (fmt2_r == FMT_SM) begin
            ovf_s = sat_s;
            if (sat_s) begin
                res_s = {1'b1, {WIDTH{1'b1}}};
            end else if (exact_s[WIDTH]) begin
                res_s = {1'b1, neg_s[WIDTH-1:0]};
            end else begin
                res_s = exact_s;
            end
        end else begin
            res_s = exact_s;
            ovf_s = 1'b0;
        end
    end

    logic [WIDTH:0] result_r;
    logic           cout_r, ovf_r;

    // Output registers; they only load when S3 can take a new entry, so a stalled result holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_r <= '0;
            cout_r   <= 1'b0;
            ovf_r    <= 1'b0;
        end else if (adv2_s) begin
            result_r <= res_s;
            cout_r   <= cin2_r[NGRP];
            ovf_r    <= ovf_s;
        end else begin
            result_r <= result_r;
            cout_r   <= cout_r;
            ovf_r    <= ovf_r;
        end
    end

    assign bus.result = result_r;
    assign bus.cout   = cout_r;
    assign bus.ovf    = ovf_r;

endmodule

// File: tb/tb_pipe_cla_addsub.sv
// Directed bench for pipe_cla_addsub (WIDTH=8, GROUP=4) with an arithmetic reference model.
module tb_pipe_cla_addsub;

    localparam int W = 8;
    localparam int G = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic clr   = 1'b0;

    always #5 clk = ~clk;

    pipe_cla_addsub_if #(.WIDTH(W)) bus ();

    pipe_cla_addsub #(.WIDTH(W), .GROUP(G), .NGRP(W / G)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [W:0] result;
        logic       cout;
        logic       ovf;
    } exp_t;

    exp_t q[$];

    task automatic chk(input string name, input logic [W:0] act, input logic [W:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain signed/unsigned arithmetic on the operand values.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic sub, input logic fmt);
        longint sa, sb, ua, ub, e, mag, lim;
        exp_t   r;
        sa  = $signed(a);
        sb  = $signed(b);
        ua  = a;
        ub  = b;
        lim = longint'(1) << W;
        e   = sub ? (sa - sb) : (sa + sb);
        r.cout = sub ? (ua >= ub) : ((ua + ub) >= lim);
        r.ovf  = 1'b0;
        if (!fmt) begin
            r.result = e[W:0];
        end else begin
            mag = (e < 0) ? -e : e;
            if (mag > lim - 1) begin
                mag   = lim - 1;
                r.ovf = 1'b1;
            end
            r.result = {(e < 0), mag[W-1:0]};
        end
        return r;
    endfunction

    logic       hold_pend = 1'b0;
    logic [W:0] hold_res;
    logic       hold_cout, hold_ovf;

    // Scoreboard: outputs checked against the model on every transfer, plus hold stability.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n || clr) begin
            q.delete();
            hold_pend = 1'b0;
        end else begin
            if (hold_pend) begin
                chk("hold_valid", bus.out_valid, 1);
                chk("hold_result", bus.result, hold_res);
                chk("hold_cout", bus.cout, hold_cout);
                chk("hold_ovf", bus.ovf, hold_ovf);
            end
            hold_pend = bus.out_valid && !bus.out_ready;
            hold_res  = bus.result;
            hold_cout = bus.cout;
            hold_ovf  = bus.ovf;
            if (bus.out_valid && bus.out_ready) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL spurious_output: got result %h with no transaction outstanding", bus.result);
                end else begin
                    e = q.pop_front();
                    chk("model_result", bus.result, e.result);
                    chk("model_cout", bus.cout, e.cout);
                    chk("model_ovf", bus.ovf, e.ovf);
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                q.push_back(model(bus.a, bus.b, bus.sub, bus.fmt));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Single transaction on an empty pipe with literal expectations and latency check.
    task automatic run_one(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                           input logic fmt, input logic [W:0] er, input logic ec, input logic eo);
        bus.a = a; bus.b = b; bus.sub = sub; bus.fmt = fmt;
        bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        @(negedge clk); chk("accept", bus.in_ready, 1);
        tick(); bus.in_valid = 1'b0;
        @(negedge clk); chk("lat1_valid", bus.out_valid, 0);
        tick();
        @(negedge clk); chk("lat2_valid", bus.out_valid, 0);
        tick();
        @(negedge clk);
        chk("lat3_valid", bus.out_valid, 1);
        chk("lit_result", bus.result, er);
        chk("lit_cout", bus.cout, ec);
        chk("lit_ovf", bus.ovf, eo);
        tick();
    endtask

    // Present one operand pair until accepted (bounded); optionally toggle out_ready each cycle.
    task automatic push(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                        input logic fmt, input logic tog);
        int n;
        n = 0;
        bus.a = a; bus.b = b; bus.sub = sub; bus.fmt = fmt; bus.in_valid = 1'b1;
        @(negedge clk);
        while (!bus.in_ready && n < 20) begin
            tick();
            if (tog) bus.out_ready = ~bus.out_ready;
            n++;
            @(negedge clk);
        end
        if (!bus.in_ready) begin
            checks++;
            errors++;
            $display("FAIL push_timeout: in_ready stayed 0 for %0d cycles", n);
        end
        tick();
        if (tog) bus.out_ready = ~bus.out_ready;
        bus.in_valid = 1'b0;
    endtask

    logic [W-1:0] tv_a   [8] = '{8'h7F, 8'h7F, 8'hFF, 8'h00, 8'h00, 8'hC0, 8'h01, 8'h80};
    logic [W-1:0] tv_b   [8] = '{8'h01, 8'h01, 8'hFF, 8'h00, 8'h80, 8'h40, 8'hFF, 8'h01};
    logic         tv_sub [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic         tv_fmt [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

    initial begin
        int         acc;
        int         n;
        logic [W-1:0] k;
        logic [W:0] exp_seq [3] = '{9'h004, 9'h006, 9'h008};

        bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.sub = 1'b0; bus.fmt = 1'b0;
        bus.out_ready = 1'b0;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_result", bus.result, 0);
        chk("rst_cout", bus.cout, 0);
        chk("rst_ovf", bus.ovf, 0);
        chk("rst_in_ready", bus.in_ready, 0);
        tick();
        rst_n = 1'b1;
        tick();

        run_one(8'd100, 8'd27, 1'b0, 1'b0, 9'h07F, 1'b0, 1'b0);
        run_one(8'h80, 8'h80, 1'b0, 1'b0, 9'h100, 1'b1, 1'b0);
        run_one(8'h80, 8'h80, 1'b0, 1'b1, 9'h1FF, 1'b1, 1'b1);
        run_one(8'd5, 8'd9, 1'b1, 1'b0, 9'h1FC, 1'b0, 1'b0);
        run_one(8'd5, 8'd9, 1'b1, 1'b1, 9'h104, 1'b0, 1'b0);
        run_one(8'h7F, 8'h80, 1'b1, 1'b1, 9'h0FF, 1'b0, 1'b0);
        run_one(8'h80, 8'h7F, 1'b1, 1'b1, 9'h1FF, 1'b1, 1'b0);

        // Back-to-back 1+1..4+4 against a stalled output.
        bus.out_ready = 1'b0;
        k = 8'd1;
        acc = 0;
        for (int c = 0; c < 6; c++) begin
            bus.a = k; bus.b = k; bus.sub = 1'b0; bus.fmt = 1'b0;
            bus.in_valid = 1'b1;
            @(negedge clk);
            if (bus.in_ready) begin
                acc++;
                k = k + 8'd1;
            end
            tick();
        end
        chk("stall_accepted", acc[W:0], 3);
        @(negedge clk);
        chk("stall_in_ready", bus.in_ready, 0);
        chk("stall_out_valid", bus.out_valid, 1);
        chk("stall_result", bus.result, 9'h002);
        tick();
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("release_valid", bus.out_valid, 1);
        chk("release_result", bus.result, 9'h002);
        chk("release_in_ready", bus.in_ready, 1);
        tick();
        bus.in_valid = 1'b0;
        for (int r = 0; r < 3; r++) begin
            @(negedge clk);
            chk("drain_valid", bus.out_valid, 1);
            chk("drain_result", bus.result, exp_seq[r]);
            tick();
        end
        @(negedge clk);
        chk("drain_empty", bus.out_valid, 0);
        tick();

        // Asynchronous reset with two transactions in flight.
        bus.out_ready = 1'b0;
        push(8'd5, 8'd5, 1'b0, 1'b0, 1'b0);
        push(8'd6, 8'd6, 1'b0, 1'b0, 1'b0);
        tick();
        @(negedge clk);
        chk("pre_reset_valid", bus.out_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("reset_async_drop", bus.out_valid, 0);
        chk("reset_in_ready", bus.in_ready, 0);
        tick();
        tick();
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("post_reset_silent", bus.out_valid, 0);
            tick();
        end

        // clr with a full pipe and a competing input/output transfer.
        bus.out_ready = 1'b0;
        push(8'd11, 8'd1, 1'b0, 1'b0, 1'b0);
        push(8'd12, 8'd1, 1'b0, 1'b0, 1'b0);
        push(8'd13, 8'd1, 1'b0, 1'b0, 1'b0);
        clr = 1'b1;
        bus.a = 8'd20; bus.b = 8'd22; bus.sub = 1'b0; bus.fmt = 1'b0;
        bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        @(negedge clk);
        chk("clr_in_ready", bus.in_ready, 0);
        chk("clr_full_valid", bus.out_valid, 1);
        tick();
        clr = 1'b0;
        @(negedge clk);
        chk("clr_flush_valid", bus.out_valid, 0);
        chk("clr_after_ready", bus.in_ready, 1);
        tick();
        bus.in_valid = 1'b0;
        @(negedge clk); chk("clr_lat1_valid", bus.out_valid, 0);
        tick();
        @(negedge clk); chk("clr_lat2_valid", bus.out_valid, 0);
        tick();
        @(negedge clk);
        chk("clr_lat3_valid", bus.out_valid, 1);
        chk("clr_lat3_result", bus.result, 9'h02A);
        tick();

        // Mixed vectors with a toggling output stall, checked by the scoreboard.
        bus.out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            push(tv_a[i], tv_b[i], tv_sub[i], tv_fmt[i], 1'b1);
        end
        bus.out_ready = 1'b1;
        n = 0;
        while (q.size() != 0 && n < 50) begin
            tick();
            n++;
        end
        @(negedge clk);
        chk("final_queue_empty", q.size(), 0);
        chk("final_out_valid", bus.out_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
